// File: rtl/ascii_pkg.sv
// Shared constants and state type for the ASCII hex transmitter.
package ascii_pkg;

    // Base codes of the three ASCII ranges a hex digit can land in.
    localparam logic [6:0] ASCII_ZERO  = 7'h30;
    localparam logic [6:0] ASCII_CAP_A = 7'h41;
    localparam logic [6:0] ASCII_LC_A  = 7'h61;

    typedef enum logic {IDLE, SEND} hex_tx_state_t;

endpackage

// File: rtl/ascii_hex_tx_if.sv
// Word-in / character-out handshake bundle for ascii_hex_tx.
// master = the side that offers words and sinks characters; slave = the converter.
interface ascii_hex_tx_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_value;
    logic             in_lc;
    logic             out_valid;
    logic             out_ready;
    logic [6:0]       char_out;
    logic             out_last;

    modport master (
        output in_valid, in_value, in_lc, out_ready,
        input  in_ready, out_valid, char_out, out_last
    );

    modport slave (
        input  in_valid, in_value, in_lc, out_ready,
        output in_ready, out_valid, char_out, out_last
    );
endinterface

// File: rtl/nibble_to_ascii.sv
// Combinational map of one 4-bit nibble to its 7-bit ASCII hex digit.
module nibble_to_ascii
    import ascii_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       lc,
    output logic [6:0] code
);

    // 0-9 map onto '0'..'9'; 10-15 onto 'A'..'F' or 'a'..'f'. Max result 0x66 fits in 7 bits.
    always_comb begin
        if (nib < 4'd10) begin
            code = ASCII_ZERO + {3'b000, nib};
        end else begin
            code = (lc ? ASCII_LC_A : ASCII_CAP_A) + {3'b000, nib} - 7'd10;
        end
    end

endmodule

// File: rtl/ascii_hex_tx.sv
// Streams a WIDTH-bit word as ASCII hex characters, most-significant nibble first,
// one character per out_valid/out_ready handshake.
// WIDTH must be a multiple of 4 and at least 4.
// Optional macro HEX_TX_ZERO_SUPPRESS_EN: skip leading '0' characters
// (an all-zero word still emits a single '0').
module ascii_hex_tx
    import ascii_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    ascii_hex_tx_if.slave bus
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    hex_tx_state_t    state;
    hex_tx_state_t    state_next;
    logic [IDX_W-1:0] index;
    logic [IDX_W-1:0] index_next;
    logic [IDX_W-1:0] start_idx;
    logic             load;
    logic [WIDTH-1:0] word;
    logic             lc;
    logic [3:0]       nib_sel;
    logic [6:0]       code;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             out_last_c;

`ifdef HEX_TX_ZERO_SUPPRESS_EN
    // Position of the most-significant non-zero nibble; 0 for an all-zero word
    // so that exactly one '0' is sent.
    function automatic logic [IDX_W-1:0] lead_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < NIB; i++) begin
            if (v[4*i +: 4] != 4'h0) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    // First character index for a newly accepted word.
    always_comb begin
        start_idx = lead_idx(bus.in_value);
    end
`else
    // First character index for a newly accepted word: always the top nibble.
    always_comb begin
        start_idx = LAST_IDX;
    end
`endif

    // State register; async reset aborts any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Character index counter, counts down from the leading nibble to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index <= '0;
        end else begin
            index <= index_next;
        end
    end

    // Word capture; the held copy keeps the stream immune to input changes mid-word.
    always_ff @(posedge clk) begin
        if (load) begin
            word <= bus.in_value;
            lc   <= bus.in_lc;
        end
    end

    // Next-state, index and handshake outputs.
    always_comb begin
        state_next  = state;
        index_next  = index;
        load        = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_last_c  = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    load       = 1'b1;
                    index_next = start_idx;
                    state_next = SEND;
                end
            end
            SEND: begin
                out_valid_c = 1'b1;
                out_last_c  = (index == '0);
                if (bus.out_ready) begin
                    if (index == '0) begin
                        state_next = IDLE;
                    end else begin
                        index_next = index - 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Select the nibble currently addressed by index.
    always_comb begin
        nib_sel = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            if (index == IDX_W'(i)) begin
                nib_sel = word[4*i +: 4];
            end
        end
    end

    nibble_to_ascii u_nib (
        .nib  (nib_sel),
        .lc   (lc),
        .code (code)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_last  = out_last_c;
    // Hold the output at 0 outside SEND so reset/idle present a clean NUL code.
    assign bus.char_out  = (state == SEND) ? code : 7'h00;

endmodule
